// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller: states, opcodes, ALUOp and ALU codes.
// Latency: none, constants only. Backpressure: n/a.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        JAL      = 4'd8,
        ALUWB    = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: ALUOp plus funct fields to the datapath ALU operation code.
// Latency: combinational. Backpressure: n/a.
module alu_dec
    import ctrl_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [2:0] f3,
    input  logic       opB5,
    input  logic       f7B5,
    output logic [2:0] aluControl
);

    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_SUB: aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (f3)
                    // Only R-type (op[5]=1) can mean sub; I-type addi reuses f7 bits as immediate
                    3'b000:  aluControl = (opB5 && f7B5) ? ALU_SUB : ALU_ADD;
                    3'b010:  aluControl = ALU_SLT;
                    3'b110:  aluControl = ALU_OR;
                    3'b111:  aluControl = ALU_AND;
                    default: aluControl = ALU_ADD;
                endcase
            end
            default: aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I-subset datapath (lw, sw, R, I, beq, jal).
// Latency: beq 3, R/I/sw/jal 4, lw 5, illegal 2 cycles. Backpressure: MEM_WAIT_EN adds mem_ready stalls in FETCH/MEMREAD/MEMWRITE.
module multicycle_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
`ifdef MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] immSrc,
    output logic       regWrite,
    output logic [2:0] aluControl,
    output logic       instrDone,
    output logic       illegal
);

    state_t     state, nextState;
    logic [1:0] aluOp;
    logic       memReady;
    logic       pcUpdate, branch, irLoad, memWe, regWe, done, badOp;
    logic       unusedF7;

`ifdef MEM_WAIT_EN
    assign memReady = mem_ready;
`else
    assign memReady = 1'b1;
`endif

    assign unusedF7 = ^{f7[6], f7[4:0]};

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        adrSrc    = 1'b0;
        resultSrc = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        aluOp     = ALUOP_ADD;
        pcUpdate  = 1'b0;
        branch    = 1'b0;
        irLoad    = 1'b0;
        memWe     = 1'b0;
        regWe     = 1'b0;
        done      = 1'b0;
        badOp     = 1'b0;
        case (state)
            FETCH: begin
                irLoad    = memReady;
                pcUpdate  = memReady;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                if (memReady) nextState = DECODE;
            end
            DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_R:         nextState = EXECR;
                    OP_I:         nextState = EXECI;
                    OP_JAL:       nextState = JAL;
                    OP_BEQ:       nextState = BEQ;
                    default: begin
                        nextState = FETCH;
                        badOp     = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                aluSrcA   = 2'b10;
                aluSrcB   = 2'b01;
                nextState = (op == OP_LW) ? MEMREAD : MEMWRITE;
            end
            MEMREAD: begin
                adrSrc = 1'b1;
                if (memReady) nextState = MEMWB;
            end
            MEMWB: begin
                resultSrc = 2'b01;
                regWe     = 1'b1;
                done      = 1'b1;
                nextState = FETCH;
            end
            MEMWRITE: begin
                // The write strobe stays up across the whole stall; completion waits for the memory
                adrSrc = 1'b1;
                memWe  = 1'b1;
                done   = memReady;
                if (memReady) nextState = FETCH;
            end
            EXECR: begin
                aluSrcA   = 2'b10;
                aluOp     = ALUOP_FUNCT;
                nextState = ALUWB;
            end
            EXECI: begin
                aluSrcA   = 2'b10;
                aluSrcB   = 2'b01;
                aluOp     = ALUOP_FUNCT;
                nextState = ALUWB;
            end
            JAL: begin
                aluSrcA   = 2'b01;
                aluSrcB   = 2'b10;
                pcUpdate  = 1'b1;
                nextState = ALUWB;
            end
            ALUWB: begin
                regWe     = 1'b1;
                done      = 1'b1;
                nextState = FETCH;
            end
            BEQ: begin
                aluSrcA   = 2'b10;
                aluOp     = ALUOP_SUB;
                branch    = 1'b1;
                done      = 1'b1;
                nextState = FETCH;
            end
            default: nextState = FETCH;
        endcase
    end

    // Reset masks every side effect so an abandoned instruction commits nothing
    assign pcWrite   = ~reset & (pcUpdate | (branch & zero));
    assign irWrite   = ~reset & irLoad;
    assign memWrite  = ~reset & memWe;
    assign regWrite  = ~reset & regWe;
    assign instrDone = ~reset & done;
    assign illegal   = ~reset & badOp;

    always_comb begin
        immSrc = 2'b00;
        case (op)
            OP_SW:   immSrc = 2'b01;
            OP_BEQ:  immSrc = 2'b10;
            OP_JAL:  immSrc = 2'b11;
            default: immSrc = 2'b00;
        endcase
    end

    alu_dec uAluDec (
        .aluOp      (aluOp),
        .f3         (f3),
        .opB5       (op[5]),
        .f7B5       (f7[5]),
        .aluControl (aluControl)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors are queued per instruction and compared at negedge.
module tb_multicycle_ctrl;

    localparam int S_F = 0, S_D = 1, S_MA = 2, S_MR = 3, S_MWB = 4, S_MW = 5,
                   S_ER = 6, S_EI = 7, S_J = 8, S_AWB = 9, S_B = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] f3 = 3'd0;
    logic [6:0] f7 = 7'd0;
    logic       zero = 1'b0;
`ifdef MEM_WAIT_EN
    logic       mem_ready = 1'b1;
`endif
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, instrDone, illegal;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0] aluControl;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .f3         (f3),
        .f7         (f7),
        .zero       (zero),
`ifdef MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .pcWrite    (pcWrite),
        .adrSrc     (adrSrc),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .resultSrc  (resultSrc),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .immSrc     (immSrc),
        .regWrite   (regWrite),
        .aluControl (aluControl),
        .instrDone  (instrDone),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] v;
        logic        rdy;
        string       tag;
    } item_t;

    item_t sbq[$];
    int    nChecks = 0;
    int    nFails  = 0;

    function automatic logic [2:0] expFunct();
        case (f3)
            3'b000:  return (op[5] && f7[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] expImm();
        if (op == 7'b0100011) return 2'b01;
        if (op == 7'b1100011) return 2'b10;
        if (op == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic expIllegal();
        return !(op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                 op == 7'b0010011 || op == 7'b1101111 || op == 7'b1100011);
    endfunction

    // pcWrite adrSrc memWrite irWrite resultSrc aluSrcA aluSrcB immSrc regWrite aluControl instrDone illegal
    function automatic logic [18:0] mk(logic pw, logic as, logic mw, logic iw, logic [1:0] rs,
                                       logic [1:0] sa, logic [1:0] sb, logic rw, logic [2:0] ac,
                                       logic dn, logic il);
        return {pw, as, mw, iw, rs, sa, sb, expImm(), rw, ac, dn, il};
    endfunction

    function automatic logic [18:0] expVec(int st, logic rdy);
        case (st)
            S_F:     return mk(rdy, 0, 0, rdy, 2'b10, 2'b00, 2'b10, 0, 3'b000, 0, 0);
            S_D:     return mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 3'b000, 0, expIllegal());
            S_MA:    return mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 3'b000, 0, 0);
            S_MR:    return mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0, 0);
            S_MWB:   return mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 3'b000, 1, 0);
            S_MW:    return mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, rdy, 0);
            S_ER:    return mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, expFunct(), 0, 0);
            S_EI:    return mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, expFunct(), 0, 0);
            S_J:     return mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 3'b000, 0, 0);
            S_AWB:   return mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 1, 0);
            default: return mk(zero, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 3'b001, 1, 0);
        endcase
    endfunction

    task automatic push(input int st, input logic rdy, input string tag);
        item_t it;
        it.v   = expVec(st, rdy);
        it.rdy = rdy;
        it.tag = tag;
        sbq.push_back(it);
    endtask

    task automatic drain();
        item_t       it;
        logic [18:0] act;
        while (sbq.size() > 0) begin
            it = sbq.pop_front();
`ifdef MEM_WAIT_EN
            mem_ready = it.rdy;
`endif
            @(negedge clk);
            act = {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, immSrc,
                   regWrite, aluControl, instrDone, illegal};
            nChecks++;
            if (act !== it.v) begin
                nFails++;
                $display("FAIL %s: outputs got %b want %b", it.tag, act, it.v);
            end
            @(posedge clk);
            #1;
        end
`ifdef MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
    endtask

    task automatic runInstr(input logic [6:0] o, input logic [2:0] f3v, input logic [6:0] f7v,
                            input logic z, input string tag);
        op = o; f3 = f3v; f7 = f7v; zero = z;
        push(S_F, 1, {tag, "/fetch"});
        push(S_D, 1, {tag, "/decode"});
        case (o)
            7'b0000011: begin
                push(S_MA, 1, {tag, "/memadr"});
                push(S_MR, 1, {tag, "/memread"});
                push(S_MWB, 1, {tag, "/memwb"});
            end
            7'b0100011: begin
                push(S_MA, 1, {tag, "/memadr"});
                push(S_MW, 1, {tag, "/memwrite"});
            end
            7'b0110011: begin
                push(S_ER, 1, {tag, "/execr"});
                push(S_AWB, 1, {tag, "/aluwb"});
            end
            7'b0010011: begin
                push(S_EI, 1, {tag, "/execi"});
                push(S_AWB, 1, {tag, "/aluwb"});
            end
            7'b1101111: begin
                push(S_J, 1, {tag, "/jal"});
                push(S_AWB, 1, {tag, "/aluwb"});
            end
            7'b1100011: push(S_B, 1, {tag, "/beq"});
            default: ;
        endcase
        drain();
    endtask

    task automatic checkResetCycle(input string tag);
        logic [5:0] act;
        @(negedge clk);
        act = {pcWrite, irWrite, memWrite, regWrite, instrDone, illegal};
        nChecks++;
        if (act !== 6'b0) begin
            nFails++;
            $display("FAIL %s: pc/ir/mem/reg/done/illegal got %b want 000000", tag, act);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op = 7'b0110011;
        for (int i = 0; i < 3; i++) checkResetCycle("reset_hold");
        reset = 1'b0;
        runInstr(7'b0110011, 3'b000, 7'b0000000, 1'b1, "first_after_reset_add");
    endtask

    task automatic test_alu();
        runInstr(7'b0110011, 3'b000, 7'b0100000, 1'b1, "r_sub");
        runInstr(7'b0110011, 3'b010, 7'b0000000, 1'b0, "r_slt");
        runInstr(7'b0110011, 3'b110, 7'b0000000, 1'b1, "r_or");
        runInstr(7'b0110011, 3'b111, 7'b0000000, 1'b0, "r_and");
        runInstr(7'b0110011, 3'b100, 7'b0100000, 1'b0, "r_f3_other");
        runInstr(7'b0010011, 3'b000, 7'b0100000, 1'b1, "i_addi_f7b5");
        runInstr(7'b0010011, 3'b111, 7'b0000000, 1'b0, "i_andi");
    endtask

    task automatic test_mem();
        runInstr(7'b0000011, 3'b010, 7'b0000000, 1'b1, "lw");
        runInstr(7'b0100011, 3'b010, 7'b0100000, 1'b1, "sw");
    endtask

    task automatic test_branch_jump();
        runInstr(7'b1100011, 3'b000, 7'b0000000, 1'b1, "beq_taken");
        runInstr(7'b1100011, 3'b000, 7'b0000000, 1'b0, "beq_not_taken");
        runInstr(7'b1101111, 3'b000, 7'b0000000, 1'b1, "jal");
    endtask

    task automatic test_illegal();
        runInstr(7'b0000000, 3'b000, 7'b0000000, 1'b1, "illegal_zero");
        runInstr(7'b1110011, 3'b000, 7'b0000000, 1'b0, "illegal_system");
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [6];
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1101111; ops[5] = 7'b1100011;
        for (int i = 0; i < 8; i++)
            runInstr(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 7)),
                     7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), "b2b");
    endtask

    task automatic test_reset_mid();
        op = 7'b0000011; f3 = 3'b010; f7 = 7'd0; zero = 1'b1;
        push(S_F, 1, "midrst_lw/fetch");
        push(S_D, 1, "midrst_lw/decode");
        push(S_MA, 1, "midrst_lw/memadr");
        push(S_MR, 1, "midrst_lw/memread");
        drain();
        reset = 1'b1;
        checkResetCycle("midrst_lw_in_memwb");
        reset = 1'b0;
        op = 7'b0000000;
        push(S_F, 1, "midrst_ill/fetch");
        drain();
        reset = 1'b1;
        checkResetCycle("midrst_illegal_in_decode");
        reset = 1'b0;
        runInstr(7'b0100011, 3'b010, 7'd0, 1'b0, "after_midrst_sw");
    endtask

`ifdef MEM_WAIT_EN
    task automatic test_mem_wait();
        op = 7'b0100011; f3 = 3'b010; f7 = 7'd0; zero = 1'b1;
        push(S_F, 0, "wait_sw/fetch_stall");
        push(S_F, 1, "wait_sw/fetch");
        push(S_D, 1, "wait_sw/decode");
        push(S_MA, 1, "wait_sw/memadr");
        push(S_MW, 0, "wait_sw/memwrite_stall1");
        push(S_MW, 0, "wait_sw/memwrite_stall2");
        push(S_MW, 1, "wait_sw/memwrite_done");
        drain();
        op = 7'b0000011;
        push(S_F, 1, "wait_lw/fetch");
        push(S_D, 1, "wait_lw/decode");
        push(S_MA, 1, "wait_lw/memadr");
        push(S_MR, 0, "wait_lw/memread_stall");
        push(S_MR, 1, "wait_lw/memread");
        push(S_MWB, 1, "wait_lw/memwb");
        drain();
        runInstr(7'b1100011, 3'b000, 7'd0, 1'b1, "wait_after_beq");
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_alu();
        test_mem();
        test_branch_jump();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
`ifdef MEM_WAIT_EN
        test_mem_wait();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
